// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the async FIFO: Gray/binary conversion and default geometry.
// Functions work on a wide word; callers zero-extend in and truncate out to their pointer width.
package fifo_pkg;

   localparam int PTR_MAX_W       = 32;
   localparam int ADDR_WIDTH_DFLT = 4;
   localparam int DEPTH           = 1 << (ADDR_WIDTH_DFLT - 1);

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Zero-extended Gray input leaves the upper binary bits at zero, so truncation is exact.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller of the async FIFO; status flags registered one wclk after the write.
// Latency: wen is combinational; backpressure: writes attempted while wfull are dropped and flagged in wovf.
module wptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DFLT,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  winc,
   input  logic                  wovf_clr,
   input  logic [ADDR_WIDTH-1:0] wq2_rptr,
   output logic [ADDR_WIDTH-1:0] wptr,
   output logic [ADDR_WIDTH-2:0] waddr,
   output logic                  wen,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH-1:0] wlevel,
   output logic                  wovf
);

   logic [ADDR_WIDTH-1:0] wbin_q, wbin_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] wlevel_q, wlevel_d;
   logic                  wfull_q, wfull_d;
   logic                  walmost_full_q, walmost_full_d;
   logic                  wovf_q, wovf_d;

   logic [ADDR_WIDTH-1:0] rptr_bin;
   logic [ADDR_WIDTH-1:0] full_gray;
   logic                  wen_int;

   always_comb begin
      wen_int        = winc & ~wfull_q;
      wbin_d         = wbin_q + {{(ADDR_WIDTH-1){1'b0}}, wen_int};
      wptr_d         = ADDR_WIDTH'(bin2gray(PTR_MAX_W'(wbin_d)));
      rptr_bin       = ADDR_WIDTH'(gray2bin(PTR_MAX_W'(wq2_rptr)));
      // Full: write pointer one lap ahead, i.e. top two Gray bits inverted, rest equal.
      full_gray      = {~wq2_rptr[ADDR_WIDTH-1:ADDR_WIDTH-2], wq2_rptr[ADDR_WIDTH-3:0]};
      wfull_d        = (wptr_d == full_gray);
      wlevel_d       = wbin_d - rptr_bin;
      walmost_full_d = (wlevel_d >= ADDR_WIDTH'(AFULL_THRESH));
      wovf_d         = (winc & wfull_q) | (wovf_q & ~wovf_clr);
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wbin_q         <= '0;
         wptr_q         <= '0;
         wlevel_q       <= '0;
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         wovf_q         <= 1'b0;
      end else begin
         wbin_q         <= wbin_d;
         wptr_q         <= wptr_d;
         wlevel_q       <= wlevel_d;
         wfull_q        <= wfull_d;
         walmost_full_q <= walmost_full_d;
         wovf_q         <= wovf_d;
      end
   end

   assign wptr         = wptr_q;
   assign waddr        = wbin_q[ADDR_WIDTH-2:0];
   assign wen          = wen_int;
   assign wfull        = wfull_q;
   assign walmost_full = walmost_full_q;
   assign wlevel       = wlevel_q;
   assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed + randomized bench for wptr_full_ctrl, checked against a write/read transaction-count model.
module tb_wptr_full_ctrl;
   import fifo_pkg::*;

   logic       wclk;
   logic       wrst_n;
   logic       winc;
   logic       wovf_clr;
   logic [3:0] wq2_rptr;
   logic [3:0] wptr;
   logic [2:0] waddr;
   logic       wen;
   logic       wfull;
   logic       walmost_full;
   logic [3:0] wlevel;
   logic       wovf;

   wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(6)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .wovf_clr     (wovf_clr),
      .wq2_rptr     (wq2_rptr),
      .wptr         (wptr),
      .waddr        (waddr),
      .wen          (wen),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int errs   = 0;
   int checks = 0;

   // Model: total writes accepted and total reads seen, as plain integers.
   int wr_total = 0;
   int rd_total = 0;
   int m_lvl    = 0;
   bit m_full   = 0;
   bit m_af     = 0;
   bit m_ovf    = 0;
   bit m_valid  = 0;

   function automatic int gray(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst_n_i, input logic inc, input logic clr);
      bit accept;
      wrst_n   = rst_n_i;
      winc     = inc;
      wovf_clr = clr;
      wq2_rptr = 4'(gray(rd_total % 16));
      #1;
      if (m_valid) begin
         chk("wen_pre", {31'd0, wen}, {31'd0, inc & ~m_full});
         chk("waddr_pre", {29'd0, waddr}, 32'(wr_total % 8));
      end
      @(posedge wclk);
      if (!rst_n_i) begin
         wr_total = 0; rd_total = 0; m_lvl = 0;
         m_full = 0; m_af = 0; m_ovf = 0; m_valid = 1;
      end else begin
         accept = inc && !m_full;
         if (inc && m_full) m_ovf = 1;
         else if (clr)      m_ovf = 0;
         if (accept) wr_total++;
         m_lvl  = wr_total - rd_total;
         m_full = (m_lvl == DEPTH);
         m_af   = (m_lvl >= 6);
      end
      #1;
      chk("wptr", {28'd0, wptr}, 32'(gray(wr_total % 16)));
      chk("waddr", {29'd0, waddr}, 32'(wr_total % 8));
      chk("wfull", {31'd0, wfull}, {31'd0, m_full});
      chk("walmost_full", {31'd0, walmost_full}, {31'd0, m_af});
      chk("wlevel", {28'd0, wlevel}, 32'(m_lvl % 16));
      chk("wovf", {31'd0, wovf}, {31'd0, m_ovf});
   endtask

   logic [3:0] fill_seq [8];
   logic [3:0] prev_wptr;
   bit         saw_wrap;
   int         rd_new;

   initial begin
      fill_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      wrst_n = 1'b0; winc = 1'b1; wovf_clr = 1'b0; wq2_rptr = 4'd0;
      saw_wrap = 0;
      @(posedge wclk); #1;

      // Reset with winc held high.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("rst_wptr", {28'd0, wptr}, 32'd0);
      chk("rst_wen", {31'd0, wen}, 32'd1);
      chk("rst_wlevel", {28'd0, wlevel}, 32'd0);

      // Fill eight slots against a stationary read pointer.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0);
         chk("fill_seq", {28'd0, wptr}, {28'd0, fill_seq[i]});
         chk("fill_afull", {31'd0, walmost_full}, (i >= 5) ? 32'd1 : 32'd0);
      end
      chk("fill_full", {31'd0, wfull}, 32'd1);
      chk("fill_level", {28'd0, wlevel}, 32'd8);

      // Overflow, sticky hold, then clear.
      step(1'b1, 1'b1, 1'b0);
      chk("ovf_wptr", {28'd0, wptr}, 32'hC);
      chk("ovf_set", {31'd0, wovf}, 32'd1);
      step(1'b1, 1'b0, 1'b0);
      chk("ovf_hold", {31'd0, wovf}, 32'd1);
      step(1'b1, 1'b0, 1'b1);
      chk("ovf_clr", {31'd0, wovf}, 32'd0);

      // Drain: read side reports three reads.
      rd_total = 3;
      step(1'b1, 1'b0, 1'b0);
      chk("drain_full", {31'd0, wfull}, 32'd0);
      chk("drain_level", {28'd0, wlevel}, 32'd5);
      chk("drain_afull", {31'd0, walmost_full}, 32'd0);
      winc = 1'b1; #1;
      chk("drain_wen1", {31'd0, wen}, 32'd1);
      winc = 1'b0; #1;
      chk("drain_wen0", {31'd0, wen}, 32'd0);

      // Wrap: alternate writes, reader kept two behind the post-write pointer.
      for (int i = 0; i < 40; i++) begin
         rd_new = wr_total + (i % 2) - 2;
         if (rd_new > rd_total) rd_total = rd_new;
         prev_wptr = wptr;
         step(1'b1, 1'((i % 2)), 1'b0);
         if (prev_wptr == 4'b1000 && wptr == 4'b0000) saw_wrap = 1;
         chk("wrap_nofull", {31'd0, wfull}, 32'd0);
         chk("wrap_lvl_le2", {31'd0, (wlevel <= 4'd2)}, 32'd1);
      end
      chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);

      // Randomized traffic with a lagging reader and occasional overflow clears.
      for (int i = 0; i < 300; i++) begin
         if (($urandom % 2) == 0 && rd_total < wr_total) rd_total++;
         step(1'b1, 1'(($urandom % 4) != 0), 1'(($urandom % 8) == 0));
      end

      // Mid-operation reset at level 5 with winc high.
      rd_total = wr_total;
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      chk("mid_level5", {28'd0, wlevel}, 32'd5);
      step(1'b0, 1'b1, 1'b0);
      chk("mid_rst_wptr", {28'd0, wptr}, 32'd0);
      chk("mid_rst_level", {28'd0, wlevel}, 32'd0);
      chk("mid_rst_afull", {31'd0, walmost_full}, 32'd0);
      wrst_n = 1'b1; winc = 1'b1; wq2_rptr = 4'd0; #1;
      chk("resume_waddr0", {29'd0, waddr}, 32'd0);
      step(1'b1, 1'b1, 1'b0);
      chk("resume_waddr1", {29'd0, waddr}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
